jk_btn_cmd: RTL and testbench

//  Front-end stage that directly drives the J/K inputs of the JK flip-flop stage.
//  Two raw push-button inputs (set, clear) are synchronised, debounced and edge-detected,

---
 rtl/jk_btn_cmd.sv | 120 ++++++++++++
 tb/tb_jk_btn_cmd.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/jk_btn_cmd.sv
// Button front end for the JK stage: sync, debounce and press-detect two raw buttons, then
// encode single-cycle J/K pulses (set->J, clr->K, both within the pairing window->J=K=1).
// Optional: define JK_CMD_CNT_EN to add the cmd_cnt issued-command counter port.
module jk_btn_cmd #(
  parameter int DB_CYCLES = 16,
  parameter int DB_W      = 8,
  parameter int PAIR_WIN  = 8,
  parameter int PW_W      = 8,
  parameter int CNT_W     = 8
) (
  input  logic             clk,
  input  logic             n_rst,
  input  logic             btn_set_raw,
  input  logic             btn_clr_raw,
  output logic             J,
  output logic             K,
  output logic             busy
`ifdef JK_CMD_CNT_EN
  ,
  output logic [CNT_W-1:0] cmd_cnt
`endif
);

  typedef enum logic {IDLE, PAIR_WAIT} state_t;

  // Channel index 0 is the set button, index 1 the clear button.
  logic [1:0]      s1;
  logic [1:0]      s2;
  logic [1:0]      db;
  logic [1:0]      db_d;
  logic [DB_W-1:0] dbc [2];
  logic [1:0]      press;

  state_t          state;
  logic            first_clr;
  logic [PW_W-1:0] win;
  logic            partner;

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      s1   <= '0;
      s2   <= '0;
      db   <= '0;
      db_d <= '0;
      for (int i = 0; i < 2; i++) dbc[i] <= '0;
    end else begin
      s1   <= {btn_clr_raw, btn_set_raw};
      s2   <= s1;
      db_d <= db;
      for (int i = 0; i < 2; i++) begin
        if (s2[i] == db[i]) begin
          dbc[i] <= '0;
        end else if (dbc[i] == DB_W'(DB_CYCLES - 1)) begin
          db[i]  <= s2[i];
          dbc[i] <= '0;
        end else begin
          dbc[i] <= dbc[i] + DB_W'(1);
        end
      end
    end
  end

  // Only rising debounced levels are commands; releases are dropped here.
  assign press   = db & ~db_d;
  assign partner = first_clr ? press[0] : press[1];

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state     <= IDLE;
      first_clr <= 1'b0;
      win       <= '0;
      J         <= 1'b0;
      K         <= 1'b0;
    end else begin
      J <= 1'b0;
      K <= 1'b0;
      case (state)
        IDLE: begin
          if (&press) begin
            J <= 1'b1;
            K <= 1'b1;
          end else if (|press) begin
            first_clr <= press[1];
            win       <= '0;
            state     <= PAIR_WAIT;
          end
        end
        PAIR_WAIT: begin
          // Partner wins over window expiry; a repeat of the first button is ignored.
          if (partner) begin
            J     <= 1'b1;
            K     <= 1'b1;
            state <= IDLE;
          end else if (win == PW_W'(PAIR_WIN - 1)) begin
            J     <= ~first_clr;
            K     <= first_clr;
            state <= IDLE;
          end else begin
            win <= win + PW_W'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign busy = (state != IDLE) | (dbc[0] != '0) | (dbc[1] != '0);

`ifdef JK_CMD_CNT_EN
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) cmd_cnt <= '0;
    else if (J | K) cmd_cnt <= cmd_cnt + CNT_W'(1);
  end
`else
  // Keeps CNT_W referenced when the counter is compiled out.
  logic [CNT_W-1:0] unused_cnt_w;
  assign unused_cnt_w = '0;
`endif

endmodule

// File: tb/tb_jk_btn_cmd.sv
// Directed bench for jk_btn_cmd: an event-level model (sample windows, press deadlines) is
// compared every cycle, plus literal latency/count checks for each scenario.
module tb_jk_btn_cmd;
  localparam int DB_CYCLES = 4;
  localparam int PAIR_WIN  = 3;
  localparam int CNT_W     = 2;

  logic clk;
  logic n_rst;
  logic btn_set_raw;
  logic btn_clr_raw;
  logic J;
  logic K;
  logic busy;
`ifdef JK_CMD_CNT_EN
  logic [CNT_W-1:0] cmd_cnt;
`endif

  jk_btn_cmd #(
    .DB_CYCLES(DB_CYCLES), .DB_W(8), .PAIR_WIN(PAIR_WIN), .PW_W(8), .CNT_W(CNT_W)
  ) dut (
    .clk(clk),
    .n_rst(n_rst),
    .btn_set_raw(btn_set_raw),
    .btn_clr_raw(btn_clr_raw),
    .J(J),
    .K(K),
`ifdef JK_CMD_CNT_EN
    .busy(busy),
    .cmd_cnt(cmd_cnt)
`else
    .busy(busy)
`endif
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Model: each channel's stable level flips once the last DB_CYCLES synchronised samples all
  // disagree with it; a press then opens a PAIR_WIN deadline for the partner button.
  bit       m_r1 [2];
  bit       m_r2 [2];
  bit       m_db [2];
  bit       m_win0 [$];
  bit       m_win1 [$];
  bit       m_last [2];
  bit       m_press [2];
  bit       m_pend;
  bit       m_pend_clr;
  int       m_deadline;
  int       m_t;
  bit       m_j, m_k;
  logic [CNT_W-1:0] m_cnt;

  function automatic bit all_are(input bit q [$], input bit v);
    if (q.size() < DB_CYCLES) return 1'b0;
    foreach (q[i]) if (q[i] != v) return 1'b0;
    return 1'b1;
  endfunction

  always @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      for (int i = 0; i < 2; i++) begin
        m_r1[i] = 0; m_r2[i] = 0; m_db[i] = 0; m_last[i] = 0; m_press[i] = 0;
      end
      m_win0.delete(); m_win1.delete();
      m_pend = 0; m_pend_clr = 0; m_deadline = 0; m_t = 0;
      m_j = 0; m_k = 0; m_cnt = '0;
    end else begin
      m_t++;
      if (m_j | m_k) m_cnt = m_cnt + 1'b1;
      m_j = 0; m_k = 0;
      if (m_pend) begin
        if (m_pend_clr ? m_press[0] : m_press[1]) begin
          m_j = 1; m_k = 1; m_pend = 0;
        end else if (m_t == m_deadline) begin
          m_j = !m_pend_clr; m_k = m_pend_clr; m_pend = 0;
        end
      end else if (m_press[0] && m_press[1]) begin
        m_j = 1; m_k = 1;
      end else if (m_press[0] || m_press[1]) begin
        m_pend = 1; m_pend_clr = m_press[1]; m_deadline = m_t + PAIR_WIN;
      end
      m_win0.push_back(m_r2[0]); if (m_win0.size() > DB_CYCLES) void'(m_win0.pop_front());
      m_win1.push_back(m_r2[1]); if (m_win1.size() > DB_CYCLES) void'(m_win1.pop_front());
      m_last[0] = m_r2[0]; m_last[1] = m_r2[1];
      m_press[0] = 0; m_press[1] = 0;
      if (all_are(m_win0, !m_db[0])) begin m_db[0] = !m_db[0]; m_press[0] = m_db[0]; end
      if (all_are(m_win1, !m_db[1])) begin m_db[1] = !m_db[1]; m_press[1] = m_db[1]; end
      m_r2[0] = m_r1[0]; m_r2[1] = m_r1[1];
      m_r1[0] = btn_set_raw; m_r1[1] = btn_clr_raw;
    end
  end

  // scoreboard: per-cycle compare plus per-scenario pulse statistics
  int t0 = 0;
  int j_cnt = 0, k_cnt = 0, jk_cnt = 0;
  int first_j = -1;
  always @(negedge clk) begin
    chk("J", int'(J), int'(m_j));
    chk("K", int'(K), int'(m_k));
    chk("busy", int'(busy), int'(m_pend | (m_last[0] != m_db[0]) | (m_last[1] != m_db[1])));
`ifdef JK_CMD_CNT_EN
    chk("cmd_cnt", int'(cmd_cnt), int'(m_cnt));
`endif
    if (J) j_cnt++;
    if (K) k_cnt++;
    if (J && K) jk_cnt++;
    if (J && first_j < 0) first_j = cyc - t0;
  end

  // driver tasks
  task automatic clear_stats();
    j_cnt = 0; k_cnt = 0; jk_cnt = 0; first_j = -1;
  endtask

  task automatic edge0();
    @(posedge clk); #1;
    t0 = cyc;
    clear_stats();
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_idle(input string name);
    int quiet = 0;
    int n = 0;
    step(4);
    while (quiet < 3 && n < 300) begin
      @(negedge clk);
      if (busy) quiet = 0; else quiet++;
      n++;
    end
    if (quiet < 3) begin
      bad++; total++;
      $display("FAIL %s_idle: busy still %0d after %0d cycles, want 0", name, busy, n);
    end
    step(2);
  endtask

  task automatic press(input bit s, input bit c, input int clr_gap);
    edge0();
    btn_set_raw = s;
    if (clr_gap == 0) btn_clr_raw = c;
    else begin
      step(clr_gap);
      btn_clr_raw = c;
    end
    step(16 - clr_gap);
    btn_set_raw = 0; btn_clr_raw = 0;
  endtask

  task automatic do_reset();
    n_rst = 0;
    step(3);
    n_rst = 1;
    step(2);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time %0t exceeded, want completion", $time);
    $fatal(1, "timeout");
  end

  initial begin
    btn_set_raw = 0; btn_clr_raw = 0; n_rst = 0;
    step(3);
    chk("rst_J", int'(J), 0);
    chk("rst_K", int'(K), 0);
    chk("rst_busy", int'(busy), 0);
    n_rst = 1;
    step(3);

    // 1: lone set press -> J only, after edge 10
    press(1, 0, 0);
    wait_idle("t1");
    chk("t1_first_j", first_j, 10);
    chk("t1_j_cnt", j_cnt, 1);
    chk("t1_k_cnt", k_cnt, 0);

    // 2: simultaneous press -> toggle after edge 7
    press(1, 1, 0);
    wait_idle("t2");
    chk("t2_first_j", first_j, 7);
    chk("t2_jk_cnt", jk_cnt, 1);
    chk("t2_j_cnt", j_cnt, 1);
    chk("t2_k_cnt", k_cnt, 1);

    // 3: clr two cycles after set -> toggle after edge 9
    press(1, 1, 2);
    wait_idle("t3");
    chk("t3_first_j", first_j, 9);
    chk("t3_jk_cnt", jk_cnt, 1);
    chk("t3_j_cnt", j_cnt, 1);

    // 3b: lone clr press -> K only
    press(0, 1, 0);
    wait_idle("t3b");
    chk("t3b_j_cnt", j_cnt, 0);
    chk("t3b_k_cnt", k_cnt, 1);

    // 4: short pulse and single-cycle glitches never settle
    edge0();
    btn_set_raw = 1; step(3); btn_set_raw = 0;
    for (int g = 0; g < 4; g++) begin
      step(2);
      btn_set_raw = 1; btn_clr_raw = (g % 2 == 1);
      step(1);
      btn_set_raw = 0; btn_clr_raw = 0;
    end
    wait_idle("t4");
    chk("t4_j_cnt", j_cnt, 0);
    chk("t4_k_cnt", k_cnt, 0);
    chk("t4_busy", int'(busy), 0);

    // 5: reset during PAIR_WAIT discards the pending command
    edge0();
    btn_set_raw = 1;
    step(8);
    n_rst = 0;
    btn_set_raw = 0;
    step(3);
    chk("t5_rst_busy", int'(busy), 0);
    n_rst = 1;
    step(20);
    chk("t5_j_cnt", j_cnt, 0);
    chk("t5_k_cnt", k_cnt, 0);
    chk("t5_busy", int'(busy), 0);

`ifdef JK_CMD_CNT_EN
    // 6: three singles and two toggles wrap the 2-bit counter to 1
    do_reset();
    press(1, 0, 0); wait_idle("t6a");
    press(0, 1, 0); wait_idle("t6b");
    press(1, 1, 0); wait_idle("t6c");
    press(1, 0, 0); wait_idle("t6d");
    press(1, 1, 1); wait_idle("t6e");
    chk("t6_cmd_cnt", int'(cmd_cnt), 1);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
